// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the front-panel button conditioner.
// The optional auto-repeat feature is enabled with the BTN_AUTO_REPEAT_EN macro.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b11,
    RELEASE_WAIT = 2'b10
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned REPEAT_DELAY_DEF    = 64;
  localparam int unsigned REPEAT_PERIOD_DEF   = 32;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, stable-count debounce FSM, level and strobes.
// Defining BTN_AUTO_REPEAT_EN adds a repeat counter that re-fires press_o while held.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_next_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_run_q, rpt_run_d;
  logic [RPT_W-1:0] rpt_last;

  // First repeat waits the long delay; later ones use the shorter period.
  assign rpt_last = rpt_run_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
    rpt_run_d = rpt_run_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_cnt_d = '0;
          rpt_run_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
`ifdef BTN_AUTO_REPEAT_EN
          // Repeat time only advances while settled in HELD; RELEASE_WAIT just pauses it.
          if (rpt_cnt_q == rpt_last) begin
            press_d   = 1'b1;
            rpt_cnt_d = '0;
            rpt_run_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_q <= '0;
      rpt_run_q <= 1'b0;
`endif
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
      rpt_run_q <= rpt_run_d;
`endif
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: independent debounced channels plus an any-press strobe.
// Auto-repeat of press strobes is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                ext_clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_press
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be in the range 1..16");
  end

  logic [CHANNELS-1:0] press_next;
  logic                any_press_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i       (ext_clk),
      .rst_i       (reset),
      .btn_i       (btn_in[i]),
      .level_o     (level_out[i]),
      .press_o     (press_pulse[i]),
      .release_o   (release_pulse[i]),
      .press_next_o(press_next[i])
    );
  end

  // Registered from the channels' next-state strobes so it lines up with press_pulse.
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: directed timing pins plus randomized bouncing,
// all checked every cycle against a consecutive-sample behavioural model.
module tb_btn_debounce_multi;

  localparam int CH = 5;
  localparam int DB = 16;
  localparam int RD = 64;
  localparam int RP = 32;

  logic          ext_clk = 1'b0;
  logic          reset   = 1'b0;
  logic [CH-1:0] btn_in  = '0;
  logic [CH-1:0] level_out;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic          any_press;

  btn_debounce_multi #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .ext_clk      (ext_clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_press    (any_press)
  );

  always #5 ext_clk = ~ext_clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: the button as seen two samples late, and how many consecutive samples disagree with the level.
  logic [CH-1:0] seen1, seen2;
  logic [CH-1:0] mLevel, mPress, mRelease;
  logic          mAny;
  int            runLen[CH];
  int            heldAge[CH];
  int            pressSeen[CH];
  int            releaseSeen[CH];
  int            holdLeft[CH];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    seen1 = '0; seen2 = '0;
    mLevel = '0; mPress = '0; mRelease = '0; mAny = 1'b0;
    for (int c = 0; c < CH; c++) begin
      runLen[c]  = 0;
      heldAge[c] = 0;
    end
  endtask

  task automatic modelStep();
    logic samp;
    logic settledHigh;
    if (reset) begin
      modelClear();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      samp        = seen2[c];
      seen2[c]    = seen1[c];
      seen1[c]    = btn_in[c];
      mPress[c]   = 1'b0;
      mRelease[c] = 1'b0;
      settledHigh = mLevel[c] && (runLen[c] == 0);
      if (samp != mLevel[c]) begin
        runLen[c]++;
        if (runLen[c] == DB) begin
          mLevel[c] = samp;
          runLen[c] = 0;
          if (samp) begin
            mPress[c]  = 1'b1;
            heldAge[c] = 0;
          end else begin
            mRelease[c] = 1'b1;
          end
        end
      end else begin
        runLen[c] = 0;
      end
`ifdef BTN_AUTO_REPEAT_EN
      if (settledHigh && samp) begin
        heldAge[c]++;
        if (heldAge[c] == RD || (heldAge[c] > RD && (heldAge[c] - RD) % RP == 0))
          mPress[c] = 1'b1;
      end
`else
      if (settledHigh && samp) heldAge[c]++;
`endif
    end
    mAny = |mPress;
  endtask

  task automatic compareAll();
    checkOutput("model level_out", level_out, mLevel);
    checkOutput("model press_pulse", press_pulse, mPress);
    checkOutput("model release_pulse", release_pulse, mRelease);
    checkOutput("model any_press", any_press, mAny);
    for (int c = 0; c < CH; c++) begin
      pressSeen[c]   += int'(press_pulse[c]);
      releaseSeen[c] += int'(release_pulse[c]);
    end
  endtask

  // One clock: the model consumes the same input the DUT samples, then outputs are compared.
  task automatic tick();
    @(posedge ext_clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic [CH-1:0] value, input int cycles);
    btn_in = value;
    repeat (cycles) tick();
  endtask

  initial begin
    int p0, r0;
    for (int c = 0; c < CH; c++) begin
      pressSeen[c] = 0; releaseSeen[c] = 0; holdLeft[c] = 0;
    end
    modelClear();

    #1 reset = 1'b1;
    #2;
    checkOutput("reset level_out", level_out, 0);
    checkOutput("reset press_pulse", press_pulse, 0);
    checkOutput("reset release_pulse", release_pulse, 0);
    checkOutput("reset any_press", any_press, 0);
    repeat (3) tick();
    reset = 1'b0;
    applyStimulus('0, 4);

    // Single press held 72 cycles: strobe exactly 17 edges after the first capturing edge.
    $display("[TB] single press latency");
    p0 = pressSeen[0];
    applyStimulus(5'b00001, 17);
    checkOutput("press before k+17", press_pulse, 0);
    checkOutput("level before k+17", level_out, 0);
    tick();
    checkOutput("press at k+17", press_pulse, 5'b00001);
    checkOutput("level at k+17", level_out, 5'b00001);
    checkOutput("any_press at k+17", any_press, 1);
    tick();
    checkOutput("press after k+17", press_pulse, 0);
    checkOutput("any_press after k+17", any_press, 0);
    checkOutput("level held", level_out, 5'b00001);
    repeat (53) tick();
    applyStimulus('0, 40);
    checkOutput("single press count", pressSeen[0] - p0, 1);
    checkOutput("level after release", level_out, 0);

    // Short excursions must not get through.
    $display("[TB] glitch rejection");
    p0 = pressSeen[0];
    applyStimulus(5'b00001, 2);
    applyStimulus('0, 30);
    applyStimulus(5'b00001, 15);
    applyStimulus('0, 30);
    checkOutput("glitch press count", pressSeen[0] - p0, 0);
    checkOutput("glitch level", level_out, 0);

    // Bouncy release produces one release strobe timed from the final fall.
    $display("[TB] release with bounce");
    applyStimulus(5'b00001, 30);
    checkOutput("bounce pre level", level_out, 5'b00001);
    p0 = pressSeen[0];
    r0 = releaseSeen[0];
    applyStimulus('0, 3);
    applyStimulus(5'b00001, 2);
    applyStimulus('0, 17);
    checkOutput("release before final", release_pulse, 0);
    checkOutput("level before final", level_out, 5'b00001);
    tick();
    checkOutput("release at final+17", release_pulse, 5'b00001);
    checkOutput("level at final+17", level_out, 0);
    repeat (22) tick();
    checkOutput("bounce release count", releaseSeen[0] - r0, 1);
    checkOutput("bounce press count", pressSeen[0] - p0, 0);

    // Several channels pressed together strobe together.
    $display("[TB] simultaneous press");
    applyStimulus(5'b10101, 17);
    checkOutput("simul press early", press_pulse, 0);
    tick();
    checkOutput("simul press", press_pulse, 5'b10101);
    checkOutput("simul any_press", any_press, 1);
    tick();
    checkOutput("simul any one-wide", any_press, 0);
    checkOutput("simul level", level_out, 5'b10101);
    applyStimulus('0, 20);

    // Reset mid-count with another channel already accepted; both re-accepted after release.
    $display("[TB] reset mid-operation");
    applyStimulus(5'b00100, 20);
    checkOutput("pre-reset level", level_out, 5'b00100);
    applyStimulus(5'b00101, 12);
    reset = 1'b1;
    modelClear();
    #2;
    checkOutput("mid reset level", level_out, 0);
    checkOutput("mid reset press", press_pulse, 0);
    checkOutput("mid reset any", any_press, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (17) tick();
    checkOutput("post reset press early", press_pulse, 0);
    checkOutput("post reset level early", level_out, 0);
    tick();
    checkOutput("post reset press at r+18", press_pulse, 5'b00101);
    checkOutput("post reset level at r+18", level_out, 5'b00101);
    checkOutput("post reset any", any_press, 1);
    applyStimulus('0, 20);

`ifdef BTN_AUTO_REPEAT_EN
    // Long hold: acceptance plus repeats at +64, +96, +128, +160.
    $display("[TB] auto repeat");
    p0 = pressSeen[0];
    applyStimulus(5'b00001, 200);
    applyStimulus('0, 40);
    checkOutput("repeat press count", pressSeen[0] - p0, 5);
`endif

    // Random bouncing with a mix of short glitches and long holds on every channel.
    $display("[TB] randomized bouncing");
    repeat (3000) begin
      for (int c = 0; c < CH; c++) begin
        if (holdLeft[c] == 0) begin
          btn_in[c]   = ~btn_in[c];
          holdLeft[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 20))
                                                     : int'($urandom_range(16, 90));
        end
        holdLeft[c]--;
      end
      tick();
    end
    applyStimulus('0, 40);
    checkOutput("final level", level_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner for the board front panel (btnd, sw and future buttons).
- Generalises the single-button handling to CHANNELS inputs: per channel, 2-flop synchroniser, stable-count debounce, clean level output, and one-cycle press/release strobes.
- Feeds the single-step/run control and switch-select logic of computer.

Parameters:
- CHANNELS, 5, number of independent button/switch inputs (1..16).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=2).
- REPEAT_DELAY, 64, cycles held before the first auto-repeat strobe (used only with the optional feature).
- REPEAT_PERIOD, 32, cycles between subsequent auto-repeat strobes (used only with the optional feature).

Ports:
- ext_clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  CHANNELS  raw asynchronous button levels, 1 = pressed.
- level_out  output  CHANNELS  debounced level per channel.
- press_pulse  output  CHANNELS  one-cycle strobe on accepted 0->1 transition (and on auto-repeat).
- release_pulse  output  CHANNELS  one-cycle strobe on accepted 1->0 transition.
- any_press  output  1  OR-reduction of press_pulse, registered in the same cycle as press_pulse.

Behaviour:
- Reset (asynchronous): all synchroniser flops, counters, level_out, press_pulse, release_pulse and any_press go to 0; every FSM goes to IDLE. Deassertion is used synchronously by the surrounding design; no reset-release filtering is done here.
- Synchroniser: btn_in[i] -> s1 -> s2 on successive edges. Only s2 is used downstream.
- Per-channel FSM, with counter width $clog2(DEBOUNCE_CYCLES):
  - IDLE (level 0): if s2=1, load cnt=1 and go to PRESS_WAIT; otherwise cnt=0.
  - PRESS_WAIT: if s2=0, return to IDLE and clear cnt. If s2=1 and cnt==DEBOUNCE_CYCLES-1, go to HELD, set level_out=1, assert press_pulse for this cycle, clear cnt. Otherwise cnt+1.
  - HELD (level 1): if s2=0, load cnt=1 and go to RELEASE_WAIT.
  - RELEASE_WAIT: mirror of PRESS_WAIT. On completion go to IDLE, set level_out=0, assert release_pulse, clear cnt. If s2=1 first, return to HELD.
- Latency: with btn_in stable from before edge k, s2 is valid after edge k+1, and level_out/strobe are registered at edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: any input excursion shorter than DEBOUNCE_CYCLES synchronised samples produces no strobe and no level change.
- Strobes are registered outputs, high exactly one cycle. press_pulse and release_pulse are never high together on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes; any_press is high if any press_pulse bit is high.
- Counter saturation cannot occur: cnt is cleared on every state exit.
- Reset asserted mid-count: count is discarded, no strobe is emitted, and level_out returns to 0 immediately, even while the button is held. After reset release, a held button is re-accepted DEBOUNCE_CYCLES+2 edges later, producing a fresh press_pulse.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: each channel has an additional repeat counter, cleared on entry to HELD.
  - After REPEAT_DELAY cycles in HELD, press_pulse re-fires for one cycle, then every REPEAT_PERIOD cycles while the FSM stays in HELD (RELEASE_WAIT pauses repeats but does not clear the counter; returning to HELD resumes).
  - level_out is unaffected.
- Undefined: no repeat counter is built; press_pulse fires once per accepted press.

Decomposition:
- Package btn_pkg:
  - state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}, 2-bit encoding 00/01/11/10.
  - Default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- Sub-module btn_debounce_chan: one channel (synchroniser, FSM, counter, optional repeat). The top module instantiates CHANNELS copies in a generate loop and ORs the press strobes into any_press.

Test Plan:
- CHANNELS=5, DEBOUNCE_CYCLES=16: reset 0 -> 1 -> 0. Then btn_in[0]=1 held 72 cycles from edge k -> press_pulse[0] high only at edge k+17; level_out[0]=1 from k+17; any_press high at k+17.
- Glitch: btn_in[0] high for 2 cycles, then for 15 cycles, with 30-cycle gaps -> no press_pulse; level_out stays 0.
- Release with bounce: held button toggles low 3 cycles, high 2, then low 40 -> single release_pulse[0] exactly 17 edges after the final fall; exactly one strobe total.
- Simultaneous: btn_in[4:0]=5'b10101 at one edge -> press_pulse=5'b10101 on the same cycle; any_press one cycle wide.
- Reset mid-operation: assert reset at cnt=10 in PRESS_WAIT -> outputs 0 immediately. With the button held through reset release, press_pulse occurs 18 edges after release.
- With BTN_AUTO_REPEAT_EN, REPEAT_DELAY=64, REPEAT_PERIOD=32, hold 200 cycles -> press strobes at acceptance, +64, +96, +128, +160 cycles, and no more before release.
